vga_output_stage: RTL and testbench

//  Downstream consumer of the 9->24-bit colour converter. It generates 640x480@60 VGA

---
 rtl/vga_output_stage_if.sv | 28 ++
 rtl/vga_output_stage.sv | 127 ++++++++++++
 tb/tb_vga_output_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vga_output_stage_if.sv
// Link between the VGA output stage and the renderer/colour-converter chain.
// Also carries the registered pins that go to the VGA DAC.
interface vga_output_stage_if;
    logic [23:0] pixel_24bit;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_start;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_clk;

    modport master (
        input  pixel_24bit,
        output pixel_x, pixel_y, video_on, frame_start,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk
    );

    modport slave (
        output pixel_24bit,
        input  pixel_x, pixel_y, video_on, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk
    );
endinterface

// File: rtl/vga_output_stage.sv
// VGA timing generator and output register stage: publishes pixel coordinates,
// samples the returned colour and emits RGB, syncs and blank_n aligned.
module vga_output_stage #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned PIPE_LAT = 0
) (
    input  logic               clk,
    input  logic               reset,
    vga_output_stage_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0] PH_LAST = 2'(CLK_DIV - 1);

    logic [1:0]  phase;
    logic        tick;
    logic [9:0]  h, v, h_next, v_next;
    logic        h_wrap, v_wrap;
    logic        video_on, frame_start;
    logic        hs_raw, vs_raw;
    logic [23:0] rgb;

    // Bit 0 of each tap vector is the undelayed value, bit i is i ticks old.
    logic [PIPE_LAT:0]   hs_dl, vs_dl, von_dl;
    logic [PIPE_LAT+1:0] hs_tap, vs_tap, von_tap;

    assign tick = (phase == PH_LAST);

    always_comb begin
        h_wrap = (h == H_LAST);
        v_wrap = (v == V_LAST);
        h_next = h_wrap ? '0 : h + 10'd1;
        v_next = v;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v + 10'd1;
        end
        hs_raw = !((h >= HS_BEG) && (h < HS_END));
        vs_raw = !((v >= VS_BEG) && (v < VS_END));
    end

    // video_on is computed from the next coordinates so it stays aligned with pixel_x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            h           <= '0;
            v           <= '0;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            phase       <= tick ? '0 : phase + 2'd1;
            frame_start <= tick && h_wrap && v_wrap;
            if (tick) begin
                h        <= h_next;
                v        <= v_next;
                video_on <= (h_next < H_VIS) && (v_next < V_VIS);
            end
        end
    end

    assign hs_tap  = {hs_dl, hs_raw};
    assign vs_tap  = {vs_dl, vs_raw};
    assign von_tap = {von_dl, video_on};

    // Colour is gated by video_on delayed PIPE_LAT ticks, matching the colour's own latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_dl  <= '1;
            vs_dl  <= '1;
            von_dl <= '0;
            rgb    <= '0;
        end else if (tick) begin
            hs_dl  <= hs_tap[PIPE_LAT:0];
            vs_dl  <= vs_tap[PIPE_LAT:0];
            von_dl <= von_tap[PIPE_LAT:0];
            rgb    <= von_tap[PIPE_LAT] ? bus.pixel_24bit : '0;
        end
    end

    generate
        if (CLK_DIV == 1) begin : g_ddr_clk
            // Behavioural stand-in for an ODDR driving 1 then 0 each cycle.
            logic clk_en;
            always_ff @(posedge clk) begin
                clk_en <= !reset;
            end
            assign bus.vga_clk = clk & clk_en;
        end else begin : g_reg_clk
            logic clk_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    clk_q <= 1'b0;
                end else begin
                    clk_q <= tick;
                end
            end
            assign bus.vga_clk = clk_q;
        end
    endgenerate

    assign bus.pixel_x     = h;
    assign bus.pixel_y     = v;
    assign bus.video_on    = video_on;
    assign bus.frame_start = frame_start;
    assign bus.vga_r       = rgb[23:16];
    assign bus.vga_g       = rgb[15:8];
    assign bus.vga_b       = rgb[7:0];
    assign bus.vga_hs      = hs_tap[PIPE_LAT+1];
    assign bus.vga_vs      = vs_tap[PIPE_LAT+1];
    assign bus.vga_blank_n = von_tap[PIPE_LAT+1];
endmodule

// File: tb/tb_vga_output_stage.sv
// Scoreboard bench for vga_output_stage on a reduced raster (24x10), two
// configurations: CLK_DIV=2/PIPE_LAT=2 and CLK_DIV=1/PIPE_LAT=0.
module tb_vga_output_stage;
    localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    typedef struct {
        int          src;
        bit          wh;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic white;
    logic end_check;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input int j, input bit wh);
        exp_t e;
        int   h, v;
        h     = j % HT;
        v     = (j / HT) % VT;
        e.src = j;
        e.wh  = wh;
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.bn  = (h < HA) && (v < VA);
        e.rgb = !e.bn ? 24'h0 : (wh ? 24'hFFFFFF : {8'(h), 8'(v), 8'hA5});
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned DIV = (g == 0) ? 2 : 1;
        localparam int unsigned LAT = (g == 0) ? 2 : 0;

        vga_output_stage_if bus();

        vga_output_stage #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .CLK_DIV(DIV), .PIPE_LAT(LAT)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );

        exp_t        q_vid[$];
        int          q_crd[$];
        logic [19:0] hist [0:LAT];
        int unsigned ph;
        int          k, cyc, nfs;

        // Timing model and converter model: pushes expectations, drives pixel_24bit.
        initial begin : model
            exp_t idle;
            bit   tk;
            idle.src = -1; idle.wh = 1'b0; idle.hs = 1'b1; idle.vs = 1'b1;
            idle.bn = 1'b0; idle.rgb = 24'h0;
            bus.pixel_24bit = '0;
            ph = 0; k = 0; cyc = 0; nfs = 0;
            forever begin
                @(posedge clk); #1;
                if (reset) begin
                    ph = 0; k = 0; cyc = 0; nfs = 0;
                    q_vid.delete();
                    q_crd.delete();
                    for (int i = 0; i < int'(LAT); i++) q_vid.push_back(idle);
                    for (int i = 0; i <= int'(LAT); i++) hist[i] = '0;
                    check($sformatf("c%0d_rst_x", g), bus.pixel_x, 0);
                    check($sformatf("c%0d_rst_y", g), bus.pixel_y, 0);
                    check($sformatf("c%0d_rst_von", g), bus.video_on, 1);
                    check($sformatf("c%0d_rst_fs", g), bus.frame_start, 0);
                    check($sformatf("c%0d_rst_hs", g), bus.vga_hs, 1);
                    check($sformatf("c%0d_rst_vs", g), bus.vga_vs, 1);
                    check($sformatf("c%0d_rst_bn", g), bus.vga_blank_n, 0);
                    check($sformatf("c%0d_rst_rgb", g), {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
                    check($sformatf("c%0d_rst_vclk", g), bus.vga_clk, 0);
                end else begin
                    tk = (ph == DIV - 1);
                    ph = tk ? 0 : ph + 1;
                    cyc++;
                    if (tk) begin
                        q_vid.push_back(make_exp(k, white));
                        k++;
                        q_crd.push_back(k);
                        for (int i = int'(LAT); i > 0; i--) hist[i] = hist[i-1];
                        hist[0] = {bus.pixel_x, bus.pixel_y};
                    end
                    check($sformatf("c%0d_frame_start", g), bus.frame_start,
                          tk && (k % FRAME == 0));
                    if (bus.frame_start === 1'b1) begin
                        nfs++;
                        check($sformatf("c%0d_frame_period", g), cyc, nfs * FRAME * DIV);
                    end
                end
                bus.pixel_24bit = white ? 24'hFFFFFF : {hist[LAT][17:10], hist[LAT][7:0], 8'hA5};
            end
        end

        // Monitor: pops on every DUT pixel clock and compares.
        initial begin : monitor
            exp_t        e;
            int          c;
            int          nb, nh, nv;
            logic [23:0] rgb;
            nb = 0; nh = 0; nv = 0;
            forever begin
                @(posedge bus.vga_clk); #2;
                if (reset) continue;
                if (q_vid.size() == 0 || q_crd.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL c%0d_underflow: got empty scoreboard expected entry at %0t", g, $time);
                    continue;
                end
                c = q_crd.pop_front();
                e = q_vid.pop_front();
                rgb = {bus.vga_r, bus.vga_g, bus.vga_b};
                check($sformatf("c%0d_pixel_x", g), bus.pixel_x, c % HT);
                check($sformatf("c%0d_pixel_y", g), bus.pixel_y, (c / HT) % VT);
                check($sformatf("c%0d_video_on", g), bus.video_on,
                      ((c % HT) < HA) && (((c / HT) % VT) < VA));
                check($sformatf("c%0d_hs", g), bus.vga_hs, e.hs);
                check($sformatf("c%0d_vs", g), bus.vga_vs, e.vs);
                check($sformatf("c%0d_blank_n", g), bus.vga_blank_n, e.bn);
                check($sformatf("c%0d_rgb", g), rgb, e.rgb);
                if (e.src >= 0 && !e.wh && (e.src % HT) == 13 && ((e.src / HT) % VT) == 4) begin
                    check($sformatf("c%0d_align_rgb", g), rgb, 24'h0D04A5);
                    check($sformatf("c%0d_align_bn", g), bus.vga_blank_n, 1);
                end
                if (e.wh && bus.vga_blank_n === 1'b0)
                    check($sformatf("c%0d_blank_black", g), rgb, 0);
                if (e.src >= 0) begin
                    if (e.src % FRAME == 0) begin
                        nb = 0; nh = 0; nv = 0;
                    end
                    nb += int'(bus.vga_blank_n === 1'b1);
                    nh += int'(bus.vga_hs === 1'b0);
                    nv += int'(bus.vga_vs === 1'b0);
                    if (e.src % FRAME == FRAME - 1) begin
                        check($sformatf("c%0d_frame_blank_cnt", g), nb, 96);
                        check($sformatf("c%0d_frame_hs_low", g), nh, 30);
                        check($sformatf("c%0d_frame_vs_low", g), nv, 48);
                    end
                end
            end
        end

        initial begin : final_check
            wait (end_check === 1'b1);
            check($sformatf("c%0d_crd_queue_left", g), q_crd.size(), 0);
            check($sformatf("c%0d_vid_queue_left", g), q_vid.size(), LAT);
        end
    end

    initial begin
        reset     = 1'b1;
        white     = 1'b0;
        end_check = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        // Two frames plus coordinate (20,7) of the CLK_DIV=2 instance: inside vsync.
        repeat (2 * (2 * FRAME + 7 * HT + 20)) @(negedge clk);
        reset = 1'b1;
        white = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (700) @(negedge clk);
        end_check = 1'b1;
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
